multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle sequencing FSM for the 16-bit MIPS core, replacing the single-cycle main decoder when the datapath shares one memory port and one ALU across cycles. It drives every datapath strobe and mux select, and emits `alu_op[1:0]` to the existing ALU control decoder: 11 = add, 10 = subtract, 00 = decode from function field. It handles a ready handshake on the shared memory port, keeps a retired-instruction counter, and traps illegal opcodes.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `opcode`  in  3: IR[15:13]; valid from DECODE onward.
  - 000 R-type, 010 j, 100 lw, 101 sw, 110 beq, 111 addi; all others are illegal.
- `mem_ready`  in  1: memory completes the current access in this cycle.
- `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write`  out  1 each: datapath strobes and selects.
- `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each: datapath strobes and selects.
- `alu_src_b`  out  2: ALU B select; 00 reg B, 01 constant 2, 10 sign-extended imm, 11 sign-extended imm<<1.
- `pc_source`  out  2: PC select; 00 ALU result, 01 ALUOut, 10 jump target.
- `alu_op`  out  2: to the ALU control decoder.
- `halted`  out  1: sticky illegal-opcode trap.
- `instr_count`  out  CNT_W: number of retired instructions.

## Operation
- Outputs not listed for a state are 0.
- **IDLE** (reset state). All outputs 0. Next state is FETCH unconditionally.
- **FETCH**. `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=11, `pc_source`=00.
  - `ir_write` and `pc_write` are 1 only in the cycle where `mem_ready`=1.
  - Hold FETCH while `mem_ready`=0; go to DECODE on `mem_ready`=1.
- **DECODE**. `alu_src_a`=0, `alu_src_b`=11, `alu_op`=11 (precomputes the branch target into ALUOut).
  - Next state by opcode: lw/sw → MEMADR, R → EXEC, addi → ADDI, beq → BRANCH, j → JUMP, illegal → HALT.
- **MEMADR**. `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Next: lw → MEMRD, sw → MEMWR.
- **MEMRD**. `mem_read`=1, `iord`=1. Hold until `mem_ready`=1, then go to MEMWB.
- **MEMWB**. `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Retires the instruction; next is FETCH.
- **MEMWR**. `mem_write`=1, `iord`=1. Hold until `mem_ready`=1; retires on the `mem_ready` cycle; next is FETCH.
- **EXEC**. `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00. Next is ALUWB.
- **ALUWB**. `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Retires; next is FETCH.
- **ADDI**. `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Next is ADDIWB.
- **ADDIWB**. `reg_write`=1, `reg_dst`=0. Retires; next is FETCH.
- **BRANCH**. `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, `pc_write_cond`=1, `pc_source`=01. Retires; next is FETCH.
- **JUMP**. `pc_write`=1, `pc_source`=10. Retires; next is FETCH.
- **HALT**. All strobes 0, `halted`=1. Absorbing state; only reset exits it.
- Retired-instruction counter:
  - `instr_count` increments by 1 in each cycle a retiring state transitions to FETCH.
  - It wraps from 2^CNT_W−1 to 0 with no flag.
  - It does not count in HALT, and illegal opcodes are not counted.
- `mem_read` and `mem_write` are never both 1 in the same cycle.

## Timing
- Outputs are Moore decodes of the state register. The exceptions are `ir_write` and `pc_write` in FETCH, which are also qualified by `mem_ready`.
- `opcode` is sampled only in DECODE and MEMADR.
- Latency with zero wait states, counting from entry to FETCH to re-entry to FETCH:
  - 5 cycles for lw.
  - 4 cycles for sw, R-type and addi.
  - 3 cycles for beq and j.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds 1 cycle. There is no timeout.
- `mem_ready` asserted outside FETCH, MEMRD and MEMWR is ignored.
- Asserting `rst_n`=0 at any time, including mid-wait:
  - Immediately forces IDLE, all outputs 0, `halted`=0 and `instr_count`=0.
  - The first FETCH occurs 1 cycle after `rst_n` rises.

## Structure
- The shared package holds:
  - The state enum (4-bit binary encoding).
  - Opcode constants `OP_R`, `OP_J`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`.
  - `alu_op` constants `ALUOP_ADD`=11, `ALUOP_SUB`=10 and `ALUOP_FUNC`=00.
  - `alu_src_b` and `pc_source` select constants.
- One sub-module, `retire_counter`, holds the CNT_W-bit wrapping counter with an `inc` enable and asynchronous active-low clear.
- The FSM next-state logic and the output decode live in the top module.

## Test plan
- **lw, zero waits.** `opcode`=100 and `mem_ready` tied to 1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `reg_write`=1 and `mem_to_reg`=1 only in MEMWB. `instr_count` goes 0→1.
- **sw with a 3-cycle memory stall.** `mem_ready` low for 3 cycles in MEMWR → `mem_write`=1 held for 4 cycles, `reg_write` never asserted, total 7 cycles.
- **R-type then beq.** R-type → `alu_op`=00 in EXEC. beq → `alu_op`=10 and `pc_write_cond`=1 in BRANCH. `instr_count`=2.
- **Illegal opcode 011.** → HALT after DECODE. `halted`=1, all strobes 0 for 20 cycles, `instr_count` unchanged.
- **Reset during a MEMRD wait.** Pull `rst_n` low mid-cycle → outputs go 0 immediately, without waiting for a clock edge. IDLE follows. FETCH with `mem_read`=1 appears one cycle after `rst_n` rises.
- **Counter wrap.** With CNT_W=4, retire 17 j instructions → `instr_count` reads 15 then 0 then 1.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM state
// encoding, opcode values, ALU-op codes and datapath mux select values.
package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDI   = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  // IR[15:13] encodings
  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  // Codes understood by the downstream ALU control decoder
  localparam logic [1:0] ALUOP_ADD  = 2'b11;
  localparam logic [1:0] ALUOP_SUB  = 2'b10;
  localparam logic [1:0] ALUOP_FUNC = 2'b00;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control/datapath bus between the multi-cycle controller and the datapath.
//   opcode, mem_ready             : datapath -> controller
//   strobes, selects and alu_op   : controller -> datapath
// master = controller side, slave = datapath side.
interface multi_cycle_control_if;
  logic [2:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [1:0] alu_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           pc_source, alu_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           pc_source, alu_op
  );
endinterface

// File: rtl/multi_cycle_control_retire_counter.sv
// Retired-instruction counter: CNT_W-bit, wraps silently to zero.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low clear
//   inc_i   : add one on this rising edge
//   count_o : current count
module retire_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle sequencing FSM for the 16-bit MIPS core. Drives every datapath
// strobe/select over a shared memory port and ALU, waits on mem_ready, counts
// retired instructions and traps illegal opcodes into a sticky HALT.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : controller side of multi_cycle_control_if
//   halted      : sticky illegal-opcode trap
//   instr_count : retired-instruction count (CNT_W bits, wraps)
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_cycle_control_if.master bus,
  output logic                  halted,
  output logic [CNT_W-1:0]      instr_count
);

  state_e state_q;
  state_e state_d;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode of state_q; only ir_write/pc_write in FETCH and the MEMWR
  // retire strobe also look at mem_ready.
  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    halted            = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.pc_source     = PCSRC_ALU;
    bus.alu_op        = ALUOP_FUNC;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_TWO;
        bus.alu_op    = ALUOP_ADD;
        bus.pc_source = PCSRC_ALU;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here
        bus.alu_src_b = SRCB_IMM_SH;
        bus.alu_op    = ALUOP_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDI;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_ADD;
        // Anything other than sw falls back to the load path
        state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_REG;
        bus.alu_op    = ALUOP_FUNC;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDI: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_ADD;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        retire            = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PCSRC_JUMP;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .inc_i   (retire),
    .count_o (instr_count)
  );

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control (CNT_W=4 to reach the wrap).
// Each instruction is expanded into its expected per-cycle output vectors
// and mem_ready schedule; latencies and retire counts are checked too.
module tb_multi_cycle_control;

  localparam int unsigned TB_CNT_W = 4;
  localparam int          CNT_MOD  = 16;

  // Output vector layout:
  // pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg
  // reg_dst reg_write alu_src_a alu_src_b[2] pc_source[2] alu_op[2] halted
  localparam logic [16:0] V_ZERO       = 17'd0;
  localparam logic [16:0] V_FETCH_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_11_0;
  localparam logic [16:0] V_FETCH_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_11_0;
  localparam logic [16:0] V_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_11_0;
  localparam logic [16:0] V_MEMADR     = 17'b0_0_0_0_0_0_0_0_0_1_10_00_11_0;
  localparam logic [16:0] V_MEMRD      = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] V_MEMWB      = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] V_MEMWR      = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] V_EXEC       = 17'b0_0_0_0_0_0_0_0_0_1_00_00_00_0;
  localparam logic [16:0] V_ALUWB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] V_ADDI       = 17'b0_0_0_0_0_0_0_0_0_1_10_00_11_0;
  localparam logic [16:0] V_ADDIWB     = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] V_BRANCH     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_10_0;
  localparam logic [16:0] V_JUMP       = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
  localparam logic [16:0] V_HALT       = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  logic clk = 1'b0;
  logic rst_n;
  logic halted;
  logic [TB_CNT_W-1:0] instr_count;
  logic [16:0] outv;

  multi_cycle_control_if bus_if ();

  multi_cycle_control #(
    .CNT_W(TB_CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.master),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  assign outv = {bus_if.pc_write, bus_if.pc_write_cond, bus_if.iord,
                 bus_if.mem_read, bus_if.mem_write, bus_if.ir_write,
                 bus_if.mem_to_reg, bus_if.reg_dst, bus_if.reg_write,
                 bus_if.alu_src_a, bus_if.alu_src_b, bus_if.pc_source,
                 bus_if.alu_op, halted};

  int errors = 0;
  int checks = 0;
  int mcount = 0;

  logic [16:0] exp_q[$];
  logic        rdy_q[$];

  typedef struct {
    logic [2:0] op;
    int         wf;
    int         wm;
    int         lat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [16:0] v, input logic r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  // Phase list of one instruction with wf fetch waits and wm memory waits
  task automatic expand(input logic [2:0] op, input int wf, input int wm);
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i < wf; i++) push(V_FETCH_WAIT, 1'b0);
    push(V_FETCH_RDY, 1'b1);
    push(V_DECODE, rnd());
    case (op)
      3'b100: begin
        push(V_MEMADR, rnd());
        for (int i = 0; i < wm; i++) push(V_MEMRD, 1'b0);
        push(V_MEMRD, 1'b1);
        push(V_MEMWB, rnd());
      end
      3'b101: begin
        push(V_MEMADR, rnd());
        for (int i = 0; i < wm; i++) push(V_MEMWR, 1'b0);
        push(V_MEMWR, 1'b1);
      end
      3'b000: begin push(V_EXEC, rnd()); push(V_ALUWB, rnd()); end
      3'b111: begin push(V_ADDI, rnd()); push(V_ADDIWB, rnd()); end
      3'b110: push(V_BRANCH, rnd());
      default: push(V_JUMP, rnd());
    endcase
  endtask

  // Entered at posedge+1 in FETCH; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [2:0] op, input int wf, input int wm,
                           output int cycles);
    logic [16:0] e;
    logic        r;
    logic        was_fetch;
    logic        now_fetch;
    expand(op, wf, wm);
    cycles = 0;
    now_fetch = 1'b0;
    while (cycles < 64) begin
      if (exp_q.size() == 0) begin
        check("instr_overrun", 32'(cycles), 32'(cycles - 1));
        break;
      end
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      bus_if.opcode    = op;
      bus_if.mem_ready = r;
      #1;
      check("outputs", 32'(outv), 32'(e));
      was_fetch = bus_if.mem_read && !bus_if.iord;
      cycles++;
      @(posedge clk);
      #1;
      now_fetch = bus_if.mem_read && !bus_if.iord;
      if (now_fetch && !was_fetch) break;
    end
    check("refetch_seen", 32'(now_fetch), 32'd1);
    check("instr_leftover", 32'(exp_q.size()), 32'd0);
    mcount = (mcount + 1) % CNT_MOD;
    check("instr_count", 32'(instr_count), 32'(mcount));
  endtask

  // Asserts reset mid-cycle, releases it between edges; returns at
  // posedge+1 of the first FETCH.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_outputs", 32'(outv), 32'(V_ZERO));
    check("rst_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    bus_if.mem_ready = 1'b0;
    #1;
    check("idle_outputs", 32'(outv), 32'(V_ZERO));
    @(posedge clk);
    #1;
    check("first_fetch", 32'(outv), 32'(V_FETCH_WAIT));
    mcount = 0;
  endtask

  initial begin
    logic [2:0] ops[6];
    logic [2:0] op;
    int cyc, wf, wm, lat;

    ops = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    tbl[0] = '{3'b000, 0, 0, 4};
    tbl[1] = '{3'b110, 0, 0, 3};
    tbl[2] = '{3'b100, 0, 0, 5};
    tbl[3] = '{3'b101, 0, 3, 7};
    tbl[4] = '{3'b111, 2, 0, 6};
    tbl[5] = '{3'b010, 0, 0, 3};
    tbl[6] = '{3'b100, 1, 2, 8};
    tbl[7] = '{3'b101, 1, 0, 5};

    rst_n = 1'b0;
    bus_if.opcode = 3'b000;
    bus_if.mem_ready = 1'b0;
    #3;
    check("por_outputs", 32'(outv), 32'(V_ZERO));
    check("por_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Directed instruction table
    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].op, tbl[i].wf, tbl[i].wm, cyc);
      check("tbl_latency", 32'(cyc), 32'(tbl[i].lat));
      if (i == 1) check("r_beq_count", 32'(instr_count), 32'd2);
    end

    // Random legal instruction stream with random waits
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      wf = $urandom_range(0, 2);
      wm = $urandom_range(0, 3);
      case (op)
        3'b100: lat = 5 + wf + wm;
        3'b101: lat = 4 + wf + wm;
        3'b000, 3'b111: lat = 4 + wf;
        default: lat = 3 + wf;
      endcase
      run_instr(op, wf, wm, cyc);
      check("rand_latency", 32'(cyc), 32'(lat));
    end

    // Counter wrap: 17 jumps from zero
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(3'b010, 0, 0, cyc);
    check("wrap_15", 32'(instr_count), 32'd15);
    run_instr(3'b010, 0, 0, cyc);
    check("wrap_0", 32'(instr_count), 32'd0);
    run_instr(3'b010, 0, 0, cyc);
    check("wrap_1", 32'(instr_count), 32'd1);

    // Reset while lw waits in MEMRD
    bus_if.opcode = 3'b100;
    bus_if.mem_ready = 1'b1;
    #1 check("lw_fetch", 32'(outv), 32'(V_FETCH_RDY));
    @(posedge clk); #1;
    bus_if.mem_ready = 1'b0;
    #1 check("lw_decode", 32'(outv), 32'(V_DECODE));
    @(posedge clk); #1;
    #1 check("lw_memadr", 32'(outv), 32'(V_MEMADR));
    @(posedge clk); #1;
    #1 check("lw_memrd_wait0", 32'(outv), 32'(V_MEMRD));
    @(posedge clk); #1;
    #1 check("lw_memrd_wait1", 32'(outv), 32'(V_MEMRD));
    do_reset();

    // Illegal opcode traps into HALT
    run_instr(3'b101, 0, 1, cyc);
    bus_if.opcode = 3'b011;
    bus_if.mem_ready = 1'b1;
    #1 check("ill_fetch", 32'(outv), 32'(V_FETCH_RDY));
    @(posedge clk); #1;
    bus_if.mem_ready = rnd();
    #1 check("ill_decode", 32'(outv), 32'(V_DECODE));
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus_if.mem_ready = rnd();
      bus_if.opcode = 3'($urandom_range(0, 7));
      #1;
      check("halt_outputs", 32'(outv), 32'(V_HALT));
      check("halt_count", 32'(instr_count), 32'(mcount));
      @(posedge clk); #1;
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
